// File: rtl/day05_pkg.sv
// Shared constants and types for the day-05 input stream writer.
package day05_pkg;

  localparam int DIGITS_DEFAULT = 20;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_DASH = 8'h2d;
  localparam logic [7:0] CH_NL   = 8'h0a;

  localparam logic KIND_RANGE = 1'b0;
  localparam logic KIND_ID    = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEP,
    S_CONV_A,
    S_EMIT_A,
    S_DASH,
    S_CONV_B,
    S_EMIT_B,
    S_NL,
    S_DONE
  } state_t;

  typedef enum logic {
    PH_RANGES,
    PH_IDS
  } phase_t;

  typedef struct packed {
    state_t state;
    phase_t phase;
    logic   conv_busy;
  } dbg_t;

endpackage

// File: rtl/day05_input_writer_if.sv
// Item port (valid/ready in) and byte port (valid/ready out) of the day-05 writer.
// Both ports: a transfer happens on the rising clk edge where valid && ready; the source
// holds its payload stable while valid is high and ready is low.
interface day05_input_writer_if #(
  parameter int N_ADDR_BITS = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_kind;
  logic [63:0]            in_lo;
  logic [63:0]            in_hi;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic [N_ADDR_BITS:0]   out_addr;
  logic                   done;
  logic                   error;

  modport master (
    output in_valid, in_kind, in_lo, in_hi, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_addr, done, error
  );

  modport slave (
    input  in_valid, in_kind, in_lo, in_hi, in_last, out_ready,
    output in_ready, out_valid, out_data, out_addr, done, error
  );

endinterface

// File: rtl/bin2bcd_serial.sv
// Iterative double-dabble: one input bit per cycle, 64 cycles after start, conv_done pulses
// in the same cycle the final bcd value is registered.
module bin2bcd_serial
  import day05_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [63:0]           bin,
  output logic                  busy,
  output logic                  conv_done,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [63:0]         sh;
  logic [6:0]          cnt;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      conv_done <= 1'b0;
      cnt       <= '0;
      sh        <= '0;
      bcd       <= '0;
    end else begin
      conv_done <= 1'b0;
      if (start) begin
        sh   <= bin;
        bcd  <= '0;
        cnt  <= 7'd64;
        busy <= 1'b1;
      end else if (busy) begin
        bcd <= {adj[4*DIGITS-2:0], sh[63]};
        sh  <= {sh[62:0], 1'b0};
        cnt <= cnt - 7'd1;
        if (cnt == 7'd1) begin
          busy      <= 1'b0;
          conv_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/day05_input_writer.sv
// Serialises ranges and IDs into the day-05 text format, one addressed byte per cycle.
// DAY05_WRITER_TRAILING_NL_EN: when defined, the final ID line is terminated with "\n".
module day05_input_writer
  import day05_pkg::*;
#(
  parameter int N_ADDR_BITS = 16,
  parameter int DIGITS      = DIGITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  day05_input_writer_if.slave  bus,
  output dbg_t                 dbg
);

  localparam int AW    = N_ADDR_BITS + 1;
  localparam int IDX_W = $clog2(DIGITS);

  state_t              state;
  phase_t              phase;
  logic                cur_kind;
  logic                cur_last;
  logic [63:0]         hi_q;
  logic [63:0]         conv_bin;
  logic                conv_start;
  logic                conv_busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] bcd;
  logic [IDX_W-1:0]    dig_idx;
  logic                any_sent;

  logic                slot_free;
  logic                addr_exhausted;
  logic                emit_req;
  logic                emit_fire;
  logic                emit_ovf;
  logic [7:0]          emit_byte;
  logic [3:0]          cur_digit;

  bin2bcd_serial #(.DIGITS(DIGITS)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .start     (conv_start),
    .bin       (conv_bin),
    .busy      (conv_busy),
    .conv_done (conv_done),
    .bcd       (bcd)
  );

  // Highest nonzero digit; an all-zero value still prints one "0".
  function automatic logic [IDX_W-1:0] msd_index(input logic [4*DIGITS-1:0] v);
    msd_index = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd0) msd_index = IDX_W'(i);
    end
  endfunction

  always_comb begin
    slot_free      = !bus.out_valid || bus.out_ready;
    addr_exhausted = any_sent && (&bus.out_addr);
    cur_digit      = bcd[{dig_idx, 2'b00} +: 4];
    emit_req       = 1'b0;
    emit_byte      = CH_NL;
    case (state)
      S_SEP, S_NL:        emit_req = 1'b1;
      S_DASH:             begin emit_req = 1'b1; emit_byte = CH_DASH; end
      S_EMIT_A, S_EMIT_B: begin emit_req = 1'b1; emit_byte = CH_0 + {4'd0, cur_digit}; end
      default:            emit_req = 1'b0;
    endcase
    emit_fire = emit_req && slot_free && !addr_exhausted;
    emit_ovf  = emit_req && slot_free && addr_exhausted;
  end

  assign dbg = '{state: state, phase: phase, conv_busy: conv_busy};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      phase         <= PH_RANGES;
      cur_kind      <= KIND_RANGE;
      cur_last      <= 1'b0;
      hi_q          <= '0;
      conv_bin      <= '0;
      conv_start    <= 1'b0;
      dig_idx       <= '0;
      any_sent      <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      if (bus.out_ready) bus.out_valid <= 1'b0;
      if (emit_fire) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= emit_byte;
        bus.out_addr  <= any_sent ? bus.out_addr + AW'(1) : '0;
        any_sent      <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            cur_kind     <= bus.in_kind;
            cur_last     <= bus.in_last;
            conv_bin     <= bus.in_lo;
            hi_q         <= bus.in_hi;
            if (bus.in_kind == KIND_RANGE) begin
              if (phase == PH_IDS) begin
                // Range after the ID section started: drop it.
                bus.error <= 1'b1;
                if (bus.in_last) state <= S_DONE;
                else bus.in_ready <= 1'b1;
              end else begin
                conv_start <= 1'b1;
                state      <= S_CONV_A;
              end
            end else if (phase == PH_RANGES) begin
              state <= S_SEP;
            end else begin
              conv_start <= 1'b1;
              state      <= S_CONV_A;
            end
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        S_SEP: begin
          if (emit_fire) begin
            phase <= PH_IDS;
            if (cur_kind == KIND_ID) begin
              conv_start <= 1'b1;
              state      <= S_CONV_A;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_CONV_A: begin
          if (conv_done) begin
            dig_idx <= msd_index(bcd);
            state   <= S_EMIT_A;
          end
        end
        S_EMIT_A: begin
          if (emit_fire) begin
            if (dig_idx != '0) begin
              dig_idx <= dig_idx - 1'b1;
            end else if (cur_kind == KIND_RANGE) begin
              state <= S_DASH;
            end else if (cur_last) begin
`ifdef DAY05_WRITER_TRAILING_NL_EN
              state <= S_NL;
`else
              state <= S_DONE;
`endif
            end else begin
              state <= S_NL;
            end
          end
        end
        S_DASH: begin
          if (emit_fire) begin
            conv_bin   <= hi_q;
            conv_start <= 1'b1;
            state      <= S_CONV_B;
          end
        end
        S_CONV_B: begin
          if (conv_done) begin
            dig_idx <= msd_index(bcd);
            state   <= S_EMIT_B;
          end
        end
        S_EMIT_B: begin
          if (emit_fire) begin
            if (dig_idx != '0) dig_idx <= dig_idx - 1'b1;
            else state <= S_NL;
          end
        end
        S_NL: begin
          if (emit_fire) begin
            if (!cur_last) state <= S_IDLE;
            else if (cur_kind == KIND_RANGE) state <= S_SEP;
            else state <= S_DONE;
          end
        end
        S_DONE: begin
          bus.in_ready <= 1'b0;
          if (slot_free) bus.done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      // Address space used up with more text to write: drop the byte and stop.
      if (emit_ovf) begin
        bus.error <= 1'b1;
        state     <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_day05_input_writer.sv
// Directed bench for day05_input_writer: stream table, byte scoreboard, stall and reset sequences.
module tb_day05_input_writer;
  import day05_pkg::*;

  localparam int NAB = 4;
  localparam int AW  = NAB + 1;

  logic clk = 1'b0;
  logic rst;
  dbg_t dbg;

  always #5 clk = ~clk;

  day05_input_writer_if #(.N_ADDR_BITS(NAB)) bus();

  day05_input_writer #(.N_ADDR_BITS(NAB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dbg (dbg)
  );

  typedef struct {
    logic        kind;
    logic [63:0] lo;
    logic [63:0] hi;
    logic        last;
  } item_t;

  typedef struct {
    int first;
    int n;
    bit rnd;
    bit exp_err;
  } test_t;

  item_t      items[13];
  test_t      tests[7];
  string      exp_s[7];
  string      tail;
  logic [7:0] exp_q[$];
  int         exp_addr;
  int         checks;
  int         failures;
  bit         check_en;
  bit         rnd_ready;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Ready changes just after the active edge so the negedge sampler sees a settled handshake.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  logic             prev_stall;
  logic [7:0]       prev_data;
  logic [AW-1:0]    prev_addr;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (check_en && prev_stall) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_data", bus.out_data, prev_data);
        check("stall_addr", bus.out_addr, prev_addr);
      end
      if (bus.out_valid && bus.out_ready && check_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_byte got=%0h at addr=%0d want=none", bus.out_data, bus.out_addr);
        end else begin
          check("byte_data", bus.out_data, exp_q.pop_front());
          check("byte_addr", bus.out_addr, exp_addr);
        end
        exp_addr++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, 8'd0);
    check({tag, "_out_addr"}, bus.out_addr, 0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_error"}, bus.error, 1'b0);
    check({tag, "_state"}, dbg.state, S_IDLE);
    check({tag, "_phase"}, dbg.phase, PH_RANGES);
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_item(input item_t it);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_kind  = it.kind;
    bus.in_lo    = it.lo;
    bus.in_hi    = it.hi;
    bus.in_last  = it.last;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 5000);
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout got=0 want=1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, bus.done, 1'b1);
  endtask

  task automatic load_expected(input string s);
    exp_q.delete();
    exp_addr = 0;
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
  endtask

  initial begin
    string ovf;
    checks        = 0;
    failures      = 0;
    check_en      = 1'b0;
    rnd_ready     = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_kind   = KIND_RANGE;
    bus.in_lo     = '0;
    bus.in_hi     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef DAY05_WRITER_TRAILING_NL_EN
    tail = "\n";
`else
    tail = "";
`endif

    items[0]  = '{KIND_RANGE, 64'd3, 64'd5, 1'b0};
    items[1]  = '{KIND_RANGE, 64'd10, 64'd14, 1'b0};
    items[2]  = '{KIND_ID, 64'd1, 64'd0, 1'b0};
    items[3]  = '{KIND_ID, 64'd5, 64'd0, 1'b1};
    items[4]  = '{KIND_ID, 64'd0, 64'd0, 1'b1};
    items[5]  = '{KIND_ID, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
    items[6]  = '{KIND_RANGE, 64'd7, 64'd9, 1'b1};
    items[7]  = '{KIND_ID, 64'd3, 64'd0, 1'b0};
    items[8]  = '{KIND_RANGE, 64'd1, 64'd2, 1'b1};
    items[9]  = '{KIND_RANGE, 64'd1000, 64'd2000, 1'b0};
    items[10] = '{KIND_RANGE, 64'd1000, 64'd2000, 1'b0};
    items[11] = '{KIND_RANGE, 64'd1000, 64'd2000, 1'b0};
    items[12] = '{KIND_RANGE, 64'd1000, 64'd2000, 1'b1};

    // 5-bit address: 32 bytes fit, the 33rd byte of the four-range stream overflows.
    ovf = {"1000-2000\n", "1000-2000\n", "1000-2000\n", "10"};

    tests[0] = '{0, 4, 1'b0, 1'b0};  exp_s[0] = {"3-5\n10-14\n\n1\n5", tail};
    tests[1] = '{0, 4, 1'b1, 1'b0};  exp_s[1] = {"3-5\n10-14\n\n1\n5", tail};
    tests[2] = '{4, 1, 1'b0, 1'b0};  exp_s[2] = {"\n0", tail};
    tests[3] = '{5, 1, 1'b0, 1'b0};  exp_s[3] = {"\n18446744073709551615", tail};
    tests[4] = '{6, 1, 1'b0, 1'b0};  exp_s[4] = "7-9\n\n";
    tests[5] = '{7, 2, 1'b0, 1'b1};  exp_s[5] = "\n3\n";
    tests[6] = '{9, 4, 1'b1, 1'b1};  exp_s[6] = ovf;

    for (int t = 0; t < 7; t++) begin
      check_en  = 1'b0;
      rnd_ready = 1'b0;
      apply_reset();
      load_expected(exp_s[t]);
      rnd_ready = tests[t].rnd;
      check_en  = 1'b1;
      for (int k = 0; k < tests[t].n; k++) send_item(items[tests[t].first + k]);
      wait_done($sformatf("t%0d", t));
      repeat (4) @(negedge clk);
      check($sformatf("t%0d_remaining", t), exp_q.size(), 0);
      check($sformatf("t%0d_error", t), bus.error, tests[t].exp_err);
      check($sformatf("t%0d_in_ready", t), bus.in_ready, 1'b0);
      check($sformatf("t%0d_out_valid", t), bus.out_valid, 1'b0);
      check($sformatf("t%0d_state", t), dbg.state, S_DONE);
    end

    // Reset in the middle of a range line, then a fresh stream from address 0.
    begin
      item_t big;
      item_t id9;
      int    n;
      check_en  = 1'b0;
      rnd_ready = 1'b0;
      apply_reset();
      big = '{KIND_RANGE, 64'd123456, 64'd7, 1'b0};
      id9 = '{KIND_ID, 64'd9, 64'd0, 1'b1};
      send_item(big);
      n = 0;
      while (!(bus.out_valid && bus.out_addr == 3) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("mid_addr_reached", bus.out_addr, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_values("mid_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      load_expected({"\n9", tail});
      check_en = 1'b1;
      send_item(id9);
      wait_done("after_rst");
      repeat (4) @(negedge clk);
      check("after_rst_remaining", exp_q.size(), 0);
      check("after_rst_error", bus.error, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
